// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the RV32-subset datapath: opcodes, FSM states,
// instruction classes, ALU operation codes and fault codes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LWI = 7'b0000111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_BR,
    CLS_IMM,
    CLS_LD,
    CLS_ST,
    CLS_LWI
  } class_t;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // CLS_NONE marks an opcode outside the supported subset.
  function automatic class_t decode_class(input logic [6:0] op);
    class_t cls;
    case (op)
      OP_R:    cls = CLS_R;
      OP_BR:   cls = CLS_BR;
      OP_IMM:  cls = CLS_IMM;
      OP_LD:   cls = CLS_LD;
      OP_ST:   cls = CLS_ST;
      OP_LWI:  cls = CLS_LWI;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready memory cycles and flags the cycle on which the
// limit is reached without the memory completing.
module mem_wait_timer #(
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST_OK = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  // A ready on the limit cycle clears instead of counting, so it never expires.
  assign expired = count && !clear && (cnt_q == LAST_OK);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM sharing one wait-stated memory port between
// instruction fetch and data access; counts retirements and halts on faults.
module multicycle_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             takebranch,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             alusrc,
  output logic [1:0]       aluop,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  class_t           class_q, class_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             halted_q, halted_d;
  logic [1:0]       err_q, err_d;
  logic             retire;
  logic             expired;

  logic req_c, we_c, irwe_c, pcwe_c, rw_c;

  mem_wait_timer #(
    .WAIT_W      (WAIT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clear   (!req_c || mem_ready),
    .count   (req_c && !mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    instret_d = instret_q;
    halted_d  = halted_q;
    err_d     = err_q;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (expired) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          err_d    = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        class_d = decode_class(opcode);
        if (class_d == CLS_NONE) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          err_d    = ERR_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          CLS_BR:         retire  = 1'b1;
          CLS_R, CLS_IMM: state_d = S_WB;
          default:        state_d = S_MEM;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (class_q == CLS_ST) retire = 1'b1;
          else                   state_d = S_WB;
        end else if (expired) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          err_d    = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        retire = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // run is only honoured at instruction boundaries.
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
      state_d   = run ? S_FETCH : S_IDLE;
    end
  end

  always_comb begin
    req_c    = 1'b0;
    we_c     = 1'b0;
    irwe_c   = 1'b0;
    pcwe_c   = 1'b0;
    rw_c     = 1'b0;
    iord     = 1'b0;
    pc_src   = 1'b0;
    memtoreg = 1'b0;
    alusrc   = 1'b0;
    aluop    = ALUOP_ADD;
    if (state_q == S_EXEC || state_q == S_MEM) begin
      case (class_q)
        CLS_R:         aluop = ALUOP_FUNCT;
        CLS_IMM:       begin aluop = ALUOP_FUNCT; alusrc = 1'b1; end
        CLS_LD, CLS_ST: begin aluop = ALUOP_ADD; alusrc = 1'b1; end
        CLS_BR:        aluop = ALUOP_SUB;
        default:       aluop = ALUOP_ADD;
      endcase
    end
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          irwe_c = 1'b1;
          pcwe_c = 1'b1;
        end
      end
      S_EXEC: begin
        if (class_q == CLS_BR) begin
          pcwe_c = takebranch;
          pc_src = 1'b1;
        end
      end
      S_MEM: begin
        req_c = 1'b1;
        iord  = 1'b1;
        we_c  = (class_q == CLS_ST);
      end
      S_WB: begin
        rw_c     = 1'b1;
        memtoreg = (class_q == CLS_LD) || (class_q == CLS_LWI);
      end
      default: begin
        req_c = 1'b0;
      end
    endcase
  end

  // Strobes are suppressed combinationally so reset blocks them mid-access.
  assign mem_req  = rst && req_c;
  assign mem_we   = rst && we_c;
  assign ir_we    = rst && irwe_c;
  assign pc_we    = rst && pcwe_c;
  assign regwrite = rst && rw_c;
  assign halted   = halted_q;
  assign err_code = err_q;
  assign instret  = instret_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      class_q   <= CLS_NONE;
      instret_q <= '0;
      halted_q  <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: each instruction is expanded into its expected per-cycle
// control trace from the instruction class and the memory wait pattern.
module tb_multicycle_sequencer;

  localparam int TIMEOUT = 15;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [6:0] T_IMM = 7'b0010011;
  localparam logic [6:0] T_LD  = 7'b0000011;
  localparam logic [6:0] T_ST  = 7'b0100011;
  localparam logic [6:0] T_LWI = 7'b0000111;

  localparam logic [13:0] V_REQ   = 14'h2000;
  localparam logic [13:0] V_WE    = 14'h1000;
  localparam logic [13:0] V_IORD  = 14'h0800;
  localparam logic [13:0] V_IRWE  = 14'h0400;
  localparam logic [13:0] V_PCWE  = 14'h0200;
  localparam logic [13:0] V_PCSRC = 14'h0100;
  localparam logic [13:0] V_RW    = 14'h0080;
  localparam logic [13:0] V_M2R   = 14'h0040;
  localparam logic [13:0] V_ASRC  = 14'h0020;
  localparam logic [13:0] V_HALT  = 14'h0004;
  localparam logic [13:0] STROBES = V_REQ | V_WE | V_IRWE | V_PCWE | V_RW;
  localparam logic [13:0] ALL     = 14'h3FFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [6:0]  opcode = 7'h13;
  logic        takebranch = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_we, pc_we, pc_src;
  logic        regwrite, memtoreg, alusrc, halted;
  logic [1:0]  aluop, err_code;
  logic [31:0] instret;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = '0;
  bit          in_idle = 1'b1;

  multicycle_sequencer #(
    .MEM_TIMEOUT (TIMEOUT),
    .WAIT_W      (4),
    .CNT_W       (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .opcode     (opcode),
    .takebranch (takebranch),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .regwrite   (regwrite),
    .memtoreg   (memtoreg),
    .alusrc     (alusrc),
    .aluop      (aluop),
    .halted     (halted),
    .err_code   (err_code),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [13:0] obs_vec();
    return {mem_req, mem_we, iord, ir_we, pc_we, pc_src, regwrite,
            memtoreg, alusrc, aluop, halted, err_code};
  endfunction

  function automatic logic [13:0] alu_vec(input logic asrc, input logic [1:0] aop);
    return (asrc ? V_ASRC : 14'd0) | {9'd0, aop, 3'd0};
  endfunction

  task automatic apply_stimulus(input logic r, input logic rv, input logic rs);
    @(negedge clk);
    rst       = rs;
    mem_ready = r;
    run       = rv;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [13:0] exp,
                              input logic [13:0] mask, input bit chk_inst);
    logic [13:0] got;
    got = obs_vec() & mask;
    checks++;
    assert (got === (exp & mask)) else begin
      errors++;
      $error("[TB] FAIL %s ctrl got=%b exp=%b", tag, got, exp & mask);
    end
    if (chk_inst) begin
      checks++;
      assert (instret === exp_instret) else begin
        errors++;
        $error("[TB] FAIL %s instret got=%0d exp=%0d", tag, instret, exp_instret);
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic rv, input logic [13:0] exp);
    apply_stimulus(r, rv, 1'b1);
    check_output(tag, exp, ALL, 1'b1);
  endtask

  task automatic do_reset(input logic r_during);
    apply_stimulus(r_during, 1'b1, 1'b0);
    check_output("rst_strobes0", 14'd0, STROBES, 1'b0);
    apply_stimulus(r_during, 1'b1, 1'b0);
    check_output("rst_strobes1", 14'd0, STROBES, 1'b0);
    exp_instret = '0;
    step("rst_idle", rnd(), 1'b0, 14'd0);
    in_idle = 1'b1;
  endtask

  task automatic halt_check(input logic [1:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      step("halt", rnd(), 1'b1, V_HALT | {12'd0, e});
    end
  endtask

  task automatic retired(input logic run_end);
    exp_instret = exp_instret + 32'd1;
    in_idle     = !run_end;
  endtask

  // fw/mw: not-ready cycles before the fetch/data access completes.
  task automatic run_instr(input logic [6:0] op, input logic tbr, input int fw,
                           input int mw, input logic run_end, input bit abort_mem);
    logic legal, is_br, has_mem, is_st, m2r, asrc;
    logic [1:0] aop;
    logic [13:0] av;
    if (in_idle) begin
      repeat ($urandom_range(0, 2)) step("idle_wait", rnd(), 1'b0, 14'd0);
      step("idle_go", rnd(), 1'b1, 14'd0);
      in_idle = 1'b0;
    end
    opcode     = op;
    takebranch = tbr;
    for (int i = 0; i < fw; i++) begin
      step("fetch_wait", 1'b0, rnd(), V_REQ);
      if (i == TIMEOUT - 1) begin
        halt_check(2'd2, 5);
        return;
      end
    end
    step("fetch_ready", 1'b1, rnd(), V_REQ | V_IRWE | V_PCWE);

    legal = 1'b1; is_br = 1'b0; has_mem = 1'b0; is_st = 1'b0;
    m2r = 1'b0; asrc = 1'b0; aop = 2'd0;
    case (op)
      T_R:     aop = 2'd2;
      T_BR:    begin is_br = 1'b1; aop = 2'd1; end
      T_IMM:   begin aop = 2'd2; asrc = 1'b1; end
      T_LD:    begin has_mem = 1'b1; m2r = 1'b1; asrc = 1'b1; end
      T_ST:    begin has_mem = 1'b1; is_st = 1'b1; asrc = 1'b1; end
      T_LWI:   begin has_mem = 1'b1; m2r = 1'b1; end
      default: legal = 1'b0;
    endcase
    av = alu_vec(asrc, aop);

    step("decode", rnd(), rnd(), 14'd0);
    if (!legal) begin
      halt_check(2'd1, 20);
      return;
    end
    if (is_br) begin
      step("exec_br", rnd(), run_end, av | V_PCSRC | (tbr ? V_PCWE : 14'd0));
      retired(run_end);
      return;
    end
    step("exec", rnd(), rnd(), av);
    if (has_mem) begin
      if (abort_mem) begin
        do_reset(1'b1);
        return;
      end
      for (int i = 0; i < mw; i++) begin
        step("mem_wait", 1'b0, rnd(), av | V_REQ | V_IORD | (is_st ? V_WE : 14'd0));
        if (i == TIMEOUT - 1) begin
          halt_check(2'd2, 5);
          return;
        end
      end
      if (is_st) begin
        step("mem_st", 1'b1, run_end, av | V_REQ | V_IORD | V_WE);
        retired(run_end);
        return;
      end
      step("mem_ld", 1'b1, rnd(), av | V_REQ | V_IORD);
    end
    step("wb", rnd(), run_end, V_RW | (m2r ? V_M2R : 14'd0));
    retired(run_end);
  endtask

  initial begin
    logic [6:0] ops [6];
    ops[0] = T_R; ops[1] = T_BR; ops[2] = T_IMM;
    ops[3] = T_LD; ops[4] = T_ST; ops[5] = T_LWI;

    do_reset(1'b0);
    $display("[TB] reset during sw data access");
    run_instr(T_ST, 1'b0, 0, 0, 1'b1, 1'b1);
    $display("[TB] directed instructions");
    run_instr(T_IMM, 1'b0, 0, 0, 1'b1, 1'b0);
    run_instr(T_LD,  1'b0, 0, 3, 1'b1, 1'b0);
    run_instr(T_BR,  1'b1, 0, 0, 1'b1, 1'b0);
    run_instr(T_BR,  1'b0, 1, 0, 1'b0, 1'b0);
    run_instr(T_LWI, 1'b0, 2, 1, 1'b1, 1'b0);
    run_instr(T_ST,  1'b0, 1, 2, 1'b0, 1'b0);

    $display("[TB] random instruction stream");
    for (int n = 0; n < 80; n++) begin
      run_instr(ops[$urandom_range(0, 5)], rnd(), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), ($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("[TB] wait limit boundaries");
    run_instr(T_R,  1'b0, TIMEOUT - 1, 0, 1'b1, 1'b0);
    run_instr(T_ST, 1'b0, 0, TIMEOUT - 1, 1'b1, 1'b0);
    run_instr(T_IMM, 1'b0, TIMEOUT, 0, 1'b1, 1'b0);
    do_reset(1'b0);
    run_instr(T_LD, 1'b0, 0, TIMEOUT, 1'b1, 1'b0);
    do_reset(1'b0);

    $display("[TB] illegal opcode");
    run_instr(7'h7F, 1'b0, 0, 0, 1'b1, 1'b0);
    do_reset(1'b1);
    run_instr(T_IMM, 1'b0, 0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
